// File: rtl/tick_counter_pkg.sv
// Shared constants and helpers for the tick counter bank.
package tick_counter_pkg;

   // Direction request encoding (1 = count up).
   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   // Boundary handling mode encoding.
   localparam logic MODE_WRAP = 1'b0;
   localparam logic MODE_SAT  = 1'b1;

   // Widest value bin2gray accepts; callers zero-extend in and truncate out
   // to their own WIDTH, which keeps the helper width-independent.
   localparam int GRAY_MAX_W = 64;

   // Binary to reflected Gray code.
   function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] v);
      return v ^ (v >> 1);
   endfunction

endpackage

// File: rtl/tick_counter_channel.sv
// One counter channel: live count, registered direction, display snapshot
// and boundary pulse. All state advances only on tick edges, except load.
// Build option: define SNAP_GRAY_EN to store the snapshot as Gray code.
module tick_counter_channel
   import tick_counter_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             tick,
   input  logic             direction,
   input  logic             sat_mode,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic [WIDTH-1:0] snap,
   output logic             term
);

   localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] CNT_MIN = {WIDTH{1'b0}};

   logic [WIDTH-1:0] count_reg, count_next;
   logic [WIDTH-1:0] snap_reg,  snap_next;
   logic             dir_reg,   dir_next;
   logic             term_reg,  term_next;
   logic [WIDTH-1:0] snap_value;

   // Snapshot encoding of the pre-update count.
`ifdef SNAP_GRAY_EN
   assign snap_value = WIDTH'(bin2gray(GRAY_MAX_W'(count_reg)));
`else
   assign snap_value = count_reg;
`endif

   // Next-state: step on tick (load wins over the step), direction and
   // snapshot refresh on every tick, term only when a step hits a boundary.
   always_comb begin
      count_next = count_reg;
      snap_next  = snap_reg;
      dir_next   = dir_reg;
      term_next  = 1'b0;
      if (tick) begin
         dir_next  = direction;
         snap_next = snap_value;
         if (load) begin
            count_next = load_val;
         end else if (dir_reg == DIR_UP) begin
            if (count_reg == CNT_MAX) begin
               term_next  = 1'b1;
               count_next = (sat_mode == MODE_SAT) ? CNT_MAX : CNT_MIN;
            end else begin
               count_next = count_reg + WIDTH'(1);
            end
         end else begin
            if (count_reg == CNT_MIN) begin
               term_next  = 1'b1;
               count_next = (sat_mode == MODE_WRAP) ? CNT_MAX : CNT_MIN;
            end else begin
               count_next = count_reg - WIDTH'(1);
            end
         end
      end else if (load) begin
         count_next = load_val;
      end
   end

   // Channel state registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         count_reg <= '0;
         snap_reg  <= '0;
         dir_reg   <= DIR_DOWN;
         term_reg  <= 1'b0;
      end else begin
         count_reg <= count_next;
         snap_reg  <= snap_next;
         dir_reg   <= dir_next;
         term_reg  <= term_next;
      end
   end

   assign count = count_reg;
   assign snap  = snap_reg;
   assign term  = term_reg;

endmodule

// File: rtl/tick_counter_bank.sv
// Multi-channel up/down counter bank driven by a clock-enable tick rather
// than a derived clock. Holds the tick divider and load decode; each
// channel lives in tick_counter_channel.
// Build option: SNAP_GRAY_EN (Gray-coded snapshots, see channel).
module tick_counter_bank
   import tick_counter_pkg::*;
#(
   parameter int NUM_CH   = 4,
   parameter int WIDTH    = 8,
   parameter int TICK_DIV = 100
) (
   input  logic                                         clk,
   input  logic                                         reset,
   input  logic                                         en,
   input  logic [NUM_CH-1:0]                            direction,
   input  logic                                         sat_mode,
   input  logic                                         load,
   input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] load_ch,
   input  logic [WIDTH-1:0]                             load_val,
   output logic                                         tick,
   output logic [NUM_CH*WIDTH-1:0]                      count,
   output logic [NUM_CH*WIDTH-1:0]                      snap,
   output logic [NUM_CH-1:0]                            term
);

   localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

   logic [DIV_W-1:0] div_reg, div_next;
   logic             tick_reg, tick_next;

   // Divider next-state: count 0..TICK_DIV-1 while enabled, flag the last
   // value so tick is high in the following cycle; disabled holds div.
   always_comb begin
      div_next  = div_reg;
      tick_next = 1'b0;
      if (en) begin
         tick_next = (div_reg == DIV_LAST);
         div_next  = (div_reg == DIV_LAST) ? '0 : div_reg + DIV_W'(1);
      end
   end

   // Divider and tick registers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         div_reg  <= '0;
         tick_reg <= 1'b0;
      end else begin
         div_reg  <= div_next;
         tick_reg <= tick_next;
      end
   end

   assign tick = tick_reg;

   // One channel per index; an out-of-range load_ch matches no channel.
   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic load_hit;
      assign load_hit = load && (load_ch == CH_W'(gi));

      tick_counter_channel #(
         .WIDTH (WIDTH)
      ) u_channel (
         .clk       (clk),
         .reset     (reset),
         .tick      (tick_reg),
         .direction (direction[gi]),
         .sat_mode  (sat_mode),
         .load      (load_hit),
         .load_val  (load_val),
         .count     (count[gi*WIDTH +: WIDTH]),
         .snap      (snap[gi*WIDTH +: WIDTH]),
         .term      (term[gi])
      );
   end

endmodule

// File: tb/tb_tick_counter_bank.sv
// Bench for tick_counter_bank: directed steps followed by random traffic,
// every cycle compared against an arithmetic reference model.
module tb_tick_counter_bank;

   localparam int NCH  = 2;
   localparam int W    = 4;
   localparam int DIV  = 4;
   localparam int MAXV = (1 << W) - 1;
`ifdef SNAP_GRAY_EN
   localparam bit GRAY = 1'b1;
`else
   localparam bit GRAY = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           reset = 1'b0;
   logic           en = 1'b0;
   logic [NCH-1:0] direction = '0;
   logic           sat_mode = 1'b0;
   logic           load = 1'b0;
   logic [0:0]     load_ch = '0;
   logic [W-1:0]   load_val = '0;
   logic           tick;
   logic [NCH*W-1:0] count, snap;
   logic [NCH-1:0] term;

   // Three-channel instance, used only to exercise an out-of-range load index.
   logic           en3 = 1'b0;
   logic [2:0]     direction3 = '0;
   logic           sat3 = 1'b0;
   logic           load3 = 1'b0;
   logic [1:0]     load_ch3 = '0;
   logic [W-1:0]   load_val3 = '0;
   logic           tick3;
   logic [3*W-1:0] count3, snap3;
   logic [2:0]     term3;

   int checks = 0;
   int errors = 0;

   // Reference model state.
   int m_div;
   bit m_tick;
   int m_cnt  [NCH];
   int m_snap [NCH];
   bit m_dir  [NCH];
   bit [NCH-1:0] m_term;

   tick_counter_bank #(.NUM_CH(NCH), .WIDTH(W), .TICK_DIV(DIV)) dut (
      .clk(clk), .reset(reset), .en(en), .direction(direction),
      .sat_mode(sat_mode), .load(load), .load_ch(load_ch), .load_val(load_val),
      .tick(tick), .count(count), .snap(snap), .term(term)
   );

   tick_counter_bank #(.NUM_CH(3), .WIDTH(W), .TICK_DIV(DIV)) dut3 (
      .clk(clk), .reset(reset), .en(en3), .direction(direction3),
      .sat_mode(sat3), .load(load3), .load_ch(load_ch3), .load_val(load_val3),
      .tick(tick3), .count(count3), .snap(snap3), .term(term3)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
         $error("check %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int snap_of(input int v);
      return GRAY ? (v ^ (v >> 1)) : v;
   endfunction

   function automatic logic [31:0] pack(input int a0, input int a1);
      logic [31:0] v = '0;
      v[W-1:0]   = a0[W-1:0];
      v[2*W-1:W] = a1[W-1:0];
      return v;
   endfunction

   // Model of one clock edge, from the behavioural rules.
   task automatic model_edge();
      bit old_tick;
      bit lhit;
      int nv;
      if (!reset) begin
         m_div = 0; m_tick = 0; m_term = '0;
         for (int c = 0; c < NCH; c++) begin
            m_cnt[c] = 0; m_snap[c] = 0; m_dir[c] = 0;
         end
      end else begin
         old_tick = m_tick;
         m_tick = en && (m_div == DIV - 1);
         if (en) m_div = (m_div + 1) % DIV;
         for (int c = 0; c < NCH; c++) begin
            lhit = load && (int'(load_ch) == c);
            m_term[c] = 1'b0;
            if (old_tick) begin
               m_snap[c] = snap_of(m_cnt[c]);
               if (lhit) begin
                  m_cnt[c] = int'(load_val);
               end else begin
                  nv = m_cnt[c] + (m_dir[c] ? 1 : -1);
                  if (nv > MAXV || nv < 0) begin
                     m_term[c] = 1'b1;
                     nv = sat_mode ? m_cnt[c] : (nv + MAXV + 1) % (MAXV + 1);
                  end
                  m_cnt[c] = nv;
               end
               m_dir[c] = direction[c];
            end else if (lhit) begin
               m_cnt[c] = int'(load_val);
            end
         end
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      #1;
      check("tick", 32'(tick), 32'(m_tick));
      check("count", 32'(count), pack(m_cnt[0], m_cnt[1]));
      check("snap", 32'(snap), pack(m_snap[0], m_snap[1]));
      check("term", 32'(term), 32'(m_term));
   endtask

   // Advance until the DUT tick is high, so the next edge is a tick edge.
   task automatic wait_tick();
      int n = 0;
      while (tick !== 1'b1 && n < 4 * DIV) begin
         cycle();
         n++;
      end
      check("tick_wait", 32'(tick), 32'd1);
   endtask

   initial begin
      // Reset state
      cycle(); cycle();
      check("rst_count", 32'(count), 32'h0);
      check("rst_snap", 32'(snap), 32'h0);
      check("rst_term", 32'(term), 32'h0);
      check("rst_tick", 32'(tick), 32'h0);
      $display("step reset: count=%h snap=%h", count, snap);

      // First tick after release steps down (dir_r reset to down)
      reset = 1'b1; en = 1'b1; direction = 2'b11;
      cycle(); cycle(); cycle();
      check("no_early_tick", 32'(tick), 32'h0);
      cycle();
      check("first_tick", 32'(tick), 32'h1);
      cycle();
      check("tick1_count", 32'(count), 32'hFF);
      check("tick1_term", 32'(term), 32'h3);
      $display("step tick1: count=%h term=%b", count, term);

      // Second tick steps up from max and wraps
      wait_tick(); cycle();
      check("tick2_count", 32'(count), 32'h00);
      check("tick2_snap", 32'(snap), GRAY ? 32'h88 : 32'hFF);
      $display("step tick2: count=%h snap=%h", count, snap);

      // Direction toggle takes effect one tick later
      direction = 2'b01;
      wait_tick(); cycle();
      check("dir_lag_count", 32'(count), 32'h11);
      wait_tick(); cycle();
      check("dir_new_count", 32'(count), 32'h02);
      check("dir_new_snap", 32'(snap), 32'h11);
      $display("step dir: count=%h snap=%h", count, snap);

      // Snapshot encoding of a captured 6
      load = 1'b1; load_ch = 1'b0; load_val = 4'd6;
      cycle();
      load = 1'b0;
      check("load6_count", 32'(count[3:0]), 32'd6);
      wait_tick(); cycle();
      check("snap6", 32'(snap[3:0]), GRAY ? 32'd5 : 32'd6);
      $display("step snap6: snap=%h", snap);

      // Saturate at max going up
      sat_mode = 1'b1;
      load = 1'b1; load_ch = 1'b0; load_val = 4'd14;
      cycle();
      load = 1'b0;
      for (int t = 0; t < 3; t++) begin
         wait_tick(); cycle();
         check("sat_count", 32'(count[3:0]), 32'd15);
         check("sat_term", 32'(term[0]), (t == 0) ? 32'd0 : 32'd1);
         $display("step sat%0d: count=%h term=%b", t, count, term);
      end

      // Load beats a coincident tick on its channel
      wait_tick();
      load = 1'b1; load_ch = 1'b1; load_val = 4'd5;
      cycle();
      load = 1'b0;
      check("ld_tick_count", 32'(count[7:4]), 32'd5);
      check("ld_tick_term", 32'(term[1]), 32'd0);
      $display("step load_tick: count=%h term=%b", count, term);

      // Out-of-range load index on the three-channel instance
      load3 = 1'b1; load_ch3 = 2'd3; load_val3 = 4'd9;
      cycle();
      check("oor_count", 32'(count3), 32'h000);
      load_ch3 = 2'd2;
      cycle();
      load3 = 1'b0;
      check("inrange_count", 32'(count3), 32'h900);
      check("inst3_idle", 32'({tick3, term3, snap3}), 32'h0);
      $display("step load_range: count3=%h", count3);

      // Enable freeze mid-period
      wait_tick(); cycle(); cycle();
      en = 1'b0;
      for (int i = 0; i < 10; i++) begin
         cycle();
         check("freeze_tick", 32'(tick), 32'd0);
      end
      en = 1'b1;
      cycle();
      check("resume_early", 32'(tick), 32'd0);
      cycle();
      check("resume_tick", 32'(tick), 32'd1);
      $display("step freeze: tick=%b", tick);

      // Random traffic against the model
      for (int i = 0; i < 400; i++) begin
         en        = ($urandom_range(0, 7) != 0);
         direction = 2'($urandom);
         if ($urandom_range(0, 15) == 0) sat_mode = ~sat_mode;
         load      = ($urandom_range(0, 5) == 0);
         load_ch   = 1'($urandom);
         load_val  = 4'($urandom);
         cycle();
      end
      $display("step random: count=%h snap=%h", count, snap);

      // Reset mid-run overrides everything
      en = 1'b1; load = 1'b1; load_val = 4'd3; reset = 1'b0;
      cycle();
      check("mid_rst_count", 32'(count), 32'h0);
      check("mid_rst_snap", 32'(snap), 32'h0);
      check("mid_rst_term", 32'(term), 32'h0);
      check("mid_rst_tick", 32'(tick), 32'h0);
      reset = 1'b1; load = 1'b0;
      repeat (6) cycle();
      $display("step mid_reset: count=%h", count);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
